// File: rtl/fp_minmax_reduce_ctrl_if.sv
// Element stream, result stream and configuration bundle for the FP min/max reduction sequencer.
interface fp_minmax_reduce_ctrl_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             start;
    logic [CNT_W-1:0] cfg_len;
    logic [1:0]       cfg_fmt;
    logic [2:0]       cfg_rm;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [64:0]      in_ext;
    logic [9:0]       in_class;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [4:0]       out_flags;
    logic             busy;

    // Issue-path / consumer side
    modport master (
        output start, cfg_len, cfg_fmt, cfg_rm,
        output in_valid, in_data, in_ext, in_class,
        output out_ready,
        input  in_ready, out_valid, out_result, out_flags, busy
    );

    // Reduction sequencer side
    modport slave (
        input  start, cfg_len, cfg_fmt, cfg_rm,
        input  in_valid, in_data, in_ext, in_class,
        input  out_ready,
        output in_ready, out_valid, out_result, out_flags, busy
    );
endinterface

// File: rtl/fp_minmax_reduce_ctrl.sv
// Reduces a stream of FP operands to a single FMIN/FMAX result through one
// combinational fp_max datapath, with a sticky invalid flag.
module fp_minmax_reduce_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input logic                        clk,
    input logic                        rst,
    fp_minmax_reduce_ctrl_if.slave     bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [63:0] CANON_S = 64'h000000007fc00000;
    localparam logic [63:0] CANON_D = 64'h7ff8000000000000;
    localparam logic [9:0]  CLS_QNAN = 10'b10_0000_0000;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       fmt_q, fmt_d;
    logic [2:0]       rm_q, rm_d;
    logic [63:0]      acc_data_q, acc_data_d;
    logic [64:0]      acc_ext_q, acc_ext_d;
    logic [9:0]       acc_class_q, acc_class_d;
    logic             inv_q, inv_d;

    // fp_max datapath signals
    logic        acc_nan, elem_nan;
    logic        elem_lt_acc, acc_lt_elem, pick_elem;
    logic [63:0] fm_result;
    logic        fm_invalid;
    logic [63:0] canon_latched;

    // fp_max: NaN-aware min/max of accumulator (op1) vs incoming element (op2)
    always_comb begin
        acc_nan       = acc_class_q[8] | acc_class_q[9];
        elem_nan      = bus.in_class[8] | bus.in_class[9];
        canon_latched = (fmt_q == 2'd0) ? CANON_S : CANON_D;
        fm_invalid    = acc_class_q[8] | bus.in_class[8];
        if (acc_ext_q[64] != bus.in_ext[64]) begin
            // differing signs: the negative operand is smaller, so -0 < +0
            elem_lt_acc = bus.in_ext[64];
            acc_lt_elem = acc_ext_q[64];
        end else if (!acc_ext_q[64]) begin
            elem_lt_acc = bus.in_ext[63:0] < acc_ext_q[63:0];
            acc_lt_elem = acc_ext_q[63:0] < bus.in_ext[63:0];
        end else begin
            elem_lt_acc = bus.in_ext[63:0] > acc_ext_q[63:0];
            acc_lt_elem = acc_ext_q[63:0] > bus.in_ext[63:0];
        end
        // rm is latched as {2'b00, max}; ties keep the accumulator
        pick_elem = (rm_q == 3'd1) ? acc_lt_elem : elem_lt_acc;
        if (acc_nan && elem_nan) begin
            fm_result = canon_latched;
        end else if (acc_nan) begin
            fm_result = bus.in_data;
        end else if (elem_nan) begin
            fm_result = acc_data_q;
        end else begin
            fm_result = pick_elem ? bus.in_data : acc_data_q;
        end
    end

    // Sequencer next-state and accumulator update
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        fmt_d       = fmt_q;
        rm_d        = rm_q;
        acc_data_d  = acc_data_q;
        acc_ext_d   = acc_ext_q;
        acc_class_d = acc_class_q;
        inv_d       = inv_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    fmt_d = bus.cfg_fmt;
                    rm_d  = {2'b00, bus.cfg_rm[0]};
                    inv_d = 1'b0;
                    if (bus.cfg_len == '0) begin
                        acc_data_d = (bus.cfg_fmt == 2'd0) ? CANON_S : CANON_D;
                        state_d    = S_DONE;
                    end else begin
                        rem_d   = bus.cfg_len;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    acc_ext_d = bus.in_ext;
                    if (elem_nan) begin
                        acc_data_d  = canon_latched;
                        acc_class_d = CLS_QNAN;
                    end else begin
                        acc_data_d  = bus.in_data;
                        acc_class_d = bus.in_class;
                    end
                    inv_d   = inv_q | bus.in_class[8];
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    acc_data_d = fm_result;
                    inv_d      = inv_q | fm_invalid;
                    if (acc_nan && elem_nan) begin
                        acc_class_d = CLS_QNAN;
                    end else if (acc_nan) begin
                        acc_ext_d   = bus.in_ext;
                        acc_class_d = bus.in_class;
                    end else if (!elem_nan && (fm_result == bus.in_data)) begin
                        acc_ext_d   = bus.in_ext;
                        acc_class_d = bus.in_class;
                    end
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            fmt_q       <= '0;
            rm_q        <= '0;
            acc_data_q  <= '0;
            acc_ext_q   <= '0;
            acc_class_q <= '0;
            inv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            fmt_q       <= fmt_d;
            rm_q        <= rm_d;
            acc_data_q  <= acc_data_d;
            acc_ext_q   <= acc_ext_d;
            acc_class_q <= acc_class_d;
            inv_q       <= inv_d;
        end
    end

    assign bus.in_ready   = (state_q == S_LOAD) || (state_q == S_ACCUM);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.out_result = acc_data_q;
    assign bus.out_flags  = {inv_q, 4'b0000};

endmodule

// File: doc/fp_minmax_reduce_ctrl.md
Name: fp_minmax_reduce_ctrl

Overview:
Sequencer that drives one internal fp_max instance to reduce a stream of N FP operands to a single FMIN or FMAX result.
- Fed from the vector/loop issue path over a valid/ready element stream.
- Holds a running accumulator (data, extend key, class) and merges one element per cycle.
- Keeps a sticky invalid flag across the whole reduction.
- Returns the result and flags over a valid/ready result port.

Parameters:
CNT_W, 8, width of the element-count register; maximum reduction length is 2^CNT_W-1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a reduction; honoured only in IDLE
cfg_len  input  CNT_W  number of elements to reduce; latched on start
cfg_fmt  input  2  0=single, 1=double; latched on start, forwarded to fp_max
cfg_rm  input  3  bit0: 0=MIN, 1=MAX; latched on start as {2'b00,cfg_rm[0]}
in_valid  input  1  element valid
in_ready  output  1  element accepted when in_valid&&in_ready
in_data  input  64  element payload
in_ext  input  65  {sign, 64-bit magnitude key}
in_class  input  10  class vector; bit8=sNaN, bit9=qNaN
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid&&out_ready
out_result  output  64  reduced value
out_flags  output  5  bit4=invalid (sticky over reduction); bits3:0 always 0
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, LOAD, ACCUM, DONE. On reset: state=IDLE, in_ready=0, out_valid=0, busy=0, out_result=0, out_flags=0, counter=0, accumulator cleared.
- Canonical NaN: fmt=0 gives 64'h000000007fc00000; any other fmt gives 64'h7ff8000000000000.
- NaN means in_class[8] or in_class[9] is set.
- IDLE:
  - start with cfg_len=0: latch cfg, load acc_data=canonical NaN and flags=0, go to DONE.
  - start with cfg_len>0: latch cfg, remaining=cfg_len, flags=0, go to LOAD.
- LOAD (in_ready=1): on accept:
  - Element is NaN: acc_data=canonical NaN, acc_class=qNaN only (bit9), acc_ext=in_ext.
  - Otherwise: acc takes in_data, in_ext, in_class unchanged.
  - flags[4] |= in_class[8].
  - remaining decrements; remaining reaches 0 → DONE, else → ACCUM.
- ACCUM (in_ready=1, one element per cycle, no bubbles): fp_max gets data1/ext1/class1=acc and data2/ext2/class2=element, plus latched fmt/rm. On accept:
  - acc_data = fp_max result; flags[4] |= fp_max flags[4].
  - Accumulator NaN and element NaN: acc_class=qNaN, acc_ext unchanged.
  - Accumulator NaN only: acc ext/class take the element's.
  - Element NaN only: acc ext/class unchanged.
  - Neither NaN: if result==in_data, take element ext/class; else keep acc ext/class.
  - remaining decrements; remaining reaches 0 → DONE.
- DONE: out_valid=1, out_result=acc_data, out_flags={flags[4],4'b0}; outputs stable until out_ready. On handshake → IDLE, out_valid low next cycle.
- Latency: out_valid rises the cycle after the last element is accepted; cfg_len=0 gives out_valid the cycle after start.
- start is ignored when not in IDLE. Elements presented in IDLE or DONE are not accepted.
- in_valid low in LOAD/ACCUM stalls the reduction: no state change, no flag change.
- rst in any state aborts the reduction: all outputs return to reset values on the next edge, and the partial result is discarded.
- fp_max is purely combinational inside this block; no other arithmetic is performed.

Test Plan:
- MAX, fmt=1, len=3: ext {0,10},{0,30},{0,20} with data 64'h…01/…03/…02 → out_result=data of ext{0,30}, flags=0, out_valid 1 cycle after 3rd accept.
- MIN, fmt=1, len=2: +0 (ext {0,0}, data 0) then -0 (ext {1,0}, data 64'h8000000000000000) → result 64'h8000000000000000, flags=0.
- MIN, fmt=1, len=3: qNaN, 64'h3ff0000000000000 (ext {0,5}), sNaN → result 64'h3ff0000000000000, flags=5'b10000.
- Edge lengths:
  - fmt=0, len=1, single sNaN → result 64'h000000007fc00000, flags=5'b10000.
  - len=0 → result 64'h000000007fc00000 with fmt=0, flags=0, one cycle after start.
- Stalls and backpressure, len=4: in_valid toggled with gaps and out_ready held low 3 cycles → result matches the no-stall run; outputs held; start pulsed while busy is ignored.
- Abort: rst asserted after 2 of 4 elements → next cycle IDLE, in_ready=0, out_valid=0, flags=0; a fresh len=1 reduction returns its element unchanged.
